reg_file_sb: RTL

//  Parametrised multi-port register file. It is the datapath operand store for the next CPU generation.
//  N combinational read ports and one synchronous write port.

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_read_port.sv | 42 ++++
 rtl/reg_file_sb.sv | 105 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, the address-width helper and the datapath typedefs for
// the scoreboarded register file.
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef logic [clog2(RF_DEPTH)-1:0] rf_addr_t;
  typedef logic [RF_WIDTH-1:0]        rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array select with range/zero masking, same-cycle
// write forwarding, and the matching busy flag.
module rf_read_port #(
  parameter int AW       = 5,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [AW-1:0]    rd_addr_i,
  input  logic [WIDTH-1:0] mem_i [DEPTH],
  input  logic [DEPTH-1:0] busy_i,
  input  logic             wr_legal_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_busy_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic addr_valid;
  logic addr_zero;
  logic fwd;

  always_comb begin
    addr_valid = ({1'b0, rd_addr_i} < DEPTH_C);
    addr_zero  = (ZERO_REG != 0) && (rd_addr_i == '0);
    // wr_legal_i already excludes out-of-range and hardwired-zero targets.
    fwd        = (BYPASS != 0) && wr_legal_i && (wr_addr_i == rd_addr_i);

    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (fwd) begin
      rd_data_o = wr_data_i;
    end else if (addr_valid && !addr_zero) begin
      rd_data_o = mem_i[rd_addr_i];
      rd_busy_o = busy_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with one write port and a per-register busy
// scoreboard used by issue logic to reserve destinations and stall on operands.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int WIDTH    = RF_WIDTH,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = clog2(DEPTH + 1)
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [NRD*AW-1:0]    in_rd_addr,
  output logic [NRD*WIDTH-1:0] out_rd_data,
  output logic [NRD-1:0]       out_rd_busy,
  input  logic                 in_wr_en,
  input  logic [AW-1:0]        in_wr_addr,
  input  logic [WIDTH-1:0]     in_wr_data,
  input  logic                 in_rsv_en,
  input  logic [AW-1:0]        in_rsv_addr,
  output logic                 out_rsv_ready,
  output logic [CW-1:0]        out_busy_cnt
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic wr_legal;
  logic rsv_valid;
  logic rsv_busy;
  logic wr_busy;
  logic wr_same;
  logic rsv_acc;
  logic cnt_inc;
  logic cnt_dec;

  always_comb begin
    wr_legal  = in_wr_en && ({1'b0, in_wr_addr} < DEPTH_C)
                && !((ZERO_REG != 0) && (in_wr_addr == '0));
    rsv_valid = ({1'b0, in_rsv_addr} < DEPTH_C)
                && !((ZERO_REG != 0) && (in_rsv_addr == '0));
    rsv_busy  = rsv_valid ? busy_q[in_rsv_addr] : 1'b0;
    wr_busy   = wr_legal ? busy_q[in_wr_addr] : 1'b0;
    wr_same   = wr_legal && (in_wr_addr == in_rsv_addr);

    // A busy destination becomes reservable in the cycle its result lands.
    out_rsv_ready = rsv_valid && (!rsv_busy || wr_same);
    rsv_acc       = in_rsv_en && out_rsv_ready;

    busy_d = busy_q;
    if (wr_legal) busy_d[in_wr_addr]  = 1'b0;
    if (rsv_acc)  busy_d[in_rsv_addr] = 1'b1;

    // Re-reserving the register being written keeps its bit set: no net change.
    cnt_inc = rsv_acc && !rsv_busy;
    cnt_dec = wr_busy && !(rsv_acc && wr_same);
    cnt_d   = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_legal) begin
      mem_q[in_wr_addr] <= in_wr_data;
    end
  end

  assign out_busy_cnt = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .AW      (AW),
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .rd_addr_i (in_rd_addr[k*AW +: AW]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
      .wr_legal_i(wr_legal),
      .wr_addr_i (in_wr_addr),
      .wr_data_i (in_wr_data),
      .rd_data_o (out_rd_data[k*WIDTH +: WIDTH]),
      .rd_busy_o (out_rd_busy[k])
    );
  end

endmodule
